// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg: register addresses, packet width and VC bit default for the cardinal NIC
package cardinal_nic_pkg;
    localparam int PKT_W = 64;
    localparam int VC_BIT_DEF = 0;
    localparam logic [0:1] NIC_IN_BUF   = 2'b00;
    localparam logic [0:1] NIC_IN_STAT  = 2'b01;
    localparam logic [0:1] NIC_OUT_BUF  = 2'b10;
    localparam logic [0:1] NIC_OUT_STAT = 2'b11;
endpackage

// File: rtl/nic_chan_buf.sv
// nic_chan_buf: one packet buffer with a full flag; loads are taken only while empty
module nic_chan_buf
    import cardinal_nic_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [0:PKT_W-1] d,
    output logic [0:PKT_W-1] q,
    output logic             full
);
    logic take;
    assign take = load && !full;
    // capture a packet when empty; a clear only empties a buffer that was already full
    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= '0;
            full <= 1'b0;
        end else begin
            if (take) q <= d;
            full <= take || (full && !clear);
        end
    end
endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic: CPU-facing NIC with in/out packet buffers; optional counters via CARDINAL_NIC_PKT_CNT_EN
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int ACC_CYCLES = 2,
    parameter int VC_BIT     = VC_BIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:1]       addr,
    input  logic [0:PKT_W-1] d_in,
    output logic [0:PKT_W-1] d_out,
    input  logic             nicEn,
    input  logic             nicWrEn,
    input  logic             net_si,
    output logic             net_ri,
    input  logic [0:PKT_W-1] net_di,
    output logic             net_so,
    input  logic             net_ro,
    output logic [0:PKT_W-1] net_do,
    input  logic             net_polarity
);
    logic [1:0]       phase;
    logic             exec, ld, st, ics, ocs;
    logic [0:PKT_W-1] icb, ocb, in_stat, out_stat;

    assign exec = nicEn && phase == 2'd0;
    assign ld   = exec && !nicWrEn;
    assign st   = exec && nicWrEn;

    // count cycles of a held access so each LD/SD executes exactly once
    always_ff @(posedge clk) begin
        if (reset || !nicEn) phase <= 2'd0;
        else phase <= (phase == 2'(ACC_CYCLES - 1)) ? 2'd0 : phase + 2'd1;
    end

    nic_chan_buf u_in (
        .clk   (clk),
        .reset (reset),
        .load  (net_si),
        .clear (ld && addr == NIC_IN_BUF),
        .d     (net_di),
        .q     (icb),
        .full  (ics)
    );

    nic_chan_buf u_out (
        .clk   (clk),
        .reset (reset),
        .load  (st && addr == NIC_OUT_BUF),
        .clear (net_so),
        .d     (d_in),
        .q     (ocb),
        .full  (ocs)
    );

    assign net_ri = !ics;
    assign net_do = ocb;
    assign net_so = ocs && net_ro && (ocb[VC_BIT] != net_polarity);

`ifdef CARDINAL_NIC_PKT_CNT_EN
    logic [31:0] rx_cnt, tx_cnt;
    // tally accepted inbound packets and completed sends, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_cnt <= '0;
            tx_cnt <= '0;
        end else begin
            if (net_si && !ics) rx_cnt <= rx_cnt + 32'd1;
            if (net_so) tx_cnt <= tx_cnt + 32'd1;
        end
    end
    assign in_stat  = {rx_cnt, 31'b0, ics};
    assign out_stat = {tx_cnt, 31'b0, ocs};
`else
    assign in_stat  = {63'b0, ics};
    assign out_stat = {63'b0, ocs};
`endif

    // registered load data, held until the next executing load
    always_ff @(posedge clk) begin
        if (reset) d_out <= '0;
        else if (ld) d_out <= addr == NIC_IN_BUF  ? icb :
                              addr == NIC_IN_STAT ? in_stat :
                              addr == NIC_OUT_BUF ? ocb : out_stat;
    end
endmodule

// File: tb/tb_cardinal_nic.sv
// tb_cardinal_nic: directed scenarios plus randomized traffic against a behavioural NIC model
module tb_cardinal_nic;
    localparam int ACC = 2;

    logic        clk = 1'b0, reset = 1'b1;
    logic [0:1]  addr = 2'b00;
    logic [0:63] d_in = '0, net_di = '0;
    logic        nicEn = 1'b0, nicWrEn = 1'b0, net_si = 1'b0, net_ro = 1'b0, net_polarity = 1'b0;
    logic [0:63] d_out, net_do;
    logic        net_ri, net_so;

    int errors = 0, checks = 0;

    logic [0:63] m_icb, m_ocb, m_dout;
    logic        m_ics, m_ocs;
    int          run;
    logic [31:0] m_rx, m_tx;

    cardinal_nic #(.ACC_CYCLES(ACC), .VC_BIT(0)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    function automatic logic model_so();
        return m_ocs && net_ro && (m_ocb[0] != net_polarity);
    endfunction

    // advance the model by one edge using the inputs currently driven, then step the DUT
    task automatic tick();
        logic ex, so, acc, clr, st;
        logic [0:63] istat, ostat;
`ifdef CARDINAL_NIC_PKT_CNT_EN
        istat = {m_rx, 31'b0, m_ics};
        ostat = {m_tx, 31'b0, m_ocs};
`else
        istat = {63'b0, m_ics};
        ostat = {63'b0, m_ocs};
`endif
        ex  = nicEn && (run % ACC) == 0;
        so  = model_so();
        acc = net_si && !m_ics;
        clr = ex && !nicWrEn && addr == 2'b00;
        st  = ex && nicWrEn && addr == 2'b10 && !m_ocs;
        if (reset) begin
            m_icb = '0; m_ocb = '0; m_dout = '0; m_ics = 0; m_ocs = 0;
            run = 0; m_rx = 0; m_tx = 0;
        end else begin
            if (ex && !nicWrEn)
                case (addr)
                    2'b00:   m_dout = m_icb;
                    2'b01:   m_dout = istat;
                    2'b10:   m_dout = m_ocb;
                    default: m_dout = ostat;
                endcase
            if (acc) begin m_icb = net_di; m_ics = 1; end
            else if (clr) m_ics = 0;
            if (st) begin m_ocb = d_in; m_ocs = 1; end
            else if (so) m_ocs = 0;
            m_rx += 32'(acc);
            m_tx += 32'(so);
            run = nicEn ? run + 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic wr, input logic [0:1] a, input logic [0:63] d);
        nicEn = 1; nicWrEn = wr; addr = a; d_in = d;
        repeat (ACC) tick();
        nicEn = 0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1;
        tick(); tick();
        reset = 0;
        tick();
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", d_out); end
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL reset_ri: got %b expected 1", net_ri); end
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", net_so); end
        checks++; if (net_do !== 64'h0) begin errors++; $display("FAIL reset_do: got %h expected 0", net_do); end
    endtask

    task automatic test_inbound();
        net_si = 1; net_di = 64'hA5A5_0000_0000_0001;
        tick();
        net_si = 0;
        checks++; if (net_ri !== 1'b0) begin errors++; $display("FAIL in_ri_full: got %b expected 0", net_ri); end
        access(0, 2'b01, '0);
        checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL in_stat: got %h expected 1", d_out); end
        nicEn = 1; nicWrEn = 0; addr = 2'b00;
        tick();
        checks++; if (d_out !== 64'hA5A5_0000_0000_0001) begin errors++; $display("FAIL in_buf: got %h expected a5a5000000000001", d_out); end
        checks++; if (net_ri !== 1'b1) begin errors++; $display("FAIL in_clear: got %b expected 1", net_ri); end
        tick();
        nicEn = 0;
        tick();
        checks++; if (d_out !== 64'hA5A5_0000_0000_0001) begin errors++; $display("FAIL in_hold: got %h expected a5a5000000000001", d_out); end
    endtask

    task automatic test_outbound();
        net_ro = 1; net_polarity = 0;
        nicEn = 1; nicWrEn = 1; addr = 2'b10; d_in = 64'h8000_0000_0000_0042;
        tick();
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL out_so: got %b expected 1", net_so); end
        checks++; if (net_do !== 64'h8000_0000_0000_0042) begin errors++; $display("FAIL out_do: got %h expected 8000000000000042", net_do); end
        tick();
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL out_sent: got %b expected 0", net_so); end
        nicEn = 0;
        tick();
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL out_single: got %b expected 0", net_so); end
    endtask

    task automatic test_polarity();
        net_ro = 1; net_polarity = 1;
        access(1, 2'b10, 64'h8000_0000_0000_0042);
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_block: got %b expected 0", net_so); end
        access(1, 2'b10, 64'h1);
        checks++; if (net_do !== 64'h8000_0000_0000_0042) begin errors++; $display("FAIL pol_drop: got %h expected 8000000000000042", net_do); end
        access(0, 2'b11, '0);
        checks++; if (d_out !== 64'h1) begin errors++; $display("FAIL pol_ocs: got %h expected 1", d_out); end
        net_polarity = 0;
        #1;
        checks++; if (net_so !== 1'b1) begin errors++; $display("FAIL pol_open: got %b expected 1", net_so); end
        tick();
        checks++; if (net_so !== 1'b0) begin errors++; $display("FAIL pol_done: got %b expected 0", net_so); end
        net_ro = 0;
    endtask

    task automatic test_overflow();
        net_si = 1; net_di = 64'h1234;
        tick();
        net_di = 64'hFFFF;
        tick();
        net_si = 0;
        access(0, 2'b00, '0);
        checks++; if (d_out !== 64'h1234) begin errors++; $display("FAIL ovf_keep: got %h expected 1234", d_out); end
    endtask

`ifdef CARDINAL_NIC_PKT_CNT_EN
    task automatic test_counters();
        reset = 1; tick(); reset = 0; tick();
        for (int i = 0; i < 3; i++) begin
            net_si = 1; net_di = 64'(i);
            tick();
            net_si = 0;
            access(0, 2'b00, '0);
        end
        net_ro = 1; net_polarity = 0;
        for (int i = 0; i < 2; i++) access(1, 2'b10, 64'h8000_0000_0000_0007);
        net_ro = 0;
        access(0, 2'b01, '0);
        checks++; if (d_out[0:31] !== 32'd3) begin errors++; $display("FAIL cnt_rx: got %0d expected 3", d_out[0:31]); end
        access(0, 2'b11, '0);
        checks++; if (d_out[0:31] !== 32'd2) begin errors++; $display("FAIL cnt_tx: got %0d expected 2", d_out[0:31]); end
        reset = 1; tick(); reset = 0;
        access(0, 2'b01, '0);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL cnt_rx_rst: got %h expected 0", d_out); end
        access(0, 2'b11, '0);
        checks++; if (d_out !== 64'h0) begin errors++; $display("FAIL cnt_tx_rst: got %h expected 0", d_out); end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(63) == 0);
            nicEn        = ($urandom_range(9) < 7);
            nicWrEn      = $urandom_range(1);
            addr         = 2'($urandom_range(3));
            d_in         = {$urandom, $urandom};
            net_si       = ($urandom_range(9) < 4);
            net_di       = {$urandom, $urandom};
            net_ro       = ($urandom_range(9) < 7);
            net_polarity = $urandom_range(1);
            tick();
            checks++; if (d_out !== m_dout) begin errors++; $display("FAIL rnd_dout @%0d: got %h expected %h", i, d_out, m_dout); end
            checks++; if (net_ri !== !m_ics) begin errors++; $display("FAIL rnd_ri @%0d: got %b expected %b", i, net_ri, !m_ics); end
            checks++; if (net_so !== model_so()) begin errors++; $display("FAIL rnd_so @%0d: got %b expected %b", i, net_so, model_so()); end
            checks++; if (net_do !== m_ocb) begin errors++; $display("FAIL rnd_do @%0d: got %h expected %h", i, net_do, m_ocb); end
        end
        reset = 0; nicEn = 0; net_si = 0; net_ro = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_inbound();
        test_outbound();
        test_polarity();
        test_overflow();
`ifdef CARDINAL_NIC_PKT_CNT_EN
        test_counters();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
